wb_ram_arbiter: RTL

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

---
 rtl/wb_ram_arbiter_if.sv | 21 ++
 rtl/wb_ram_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter_if.sv
// Wishbone bus bundle (B3, registered-feedback tags) shared by the arbiter's masters and the RAM slave.
interface wb_ram_arbiter_if;
    localparam int unsigned ADR_W = 30;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic [DAT_W-1:0] rdt;
    logic             ack;
    logic             err;

    modport master (output cyc, stb, we, adr, dat, sel, cti, bte, input  rdt, ack, err);
    modport slave  (input  cyc, stb, we, adr, dat, sel, cti, bte, output rdt, ack, err);
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single RAM slave, with a
// per-strobe watchdog that forces a bus error when the slave never answers.
module wb_ram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    wb_ram_arbiter_if.slave  wb_m0,
    wb_ram_arbiter_if.slave  wb_m1,
    wb_ram_arbiter_if.master wb_s,
    output logic             o_timeout,
    output logic [1:0]       o_gnt
);
    localparam int unsigned   CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             g_cyc;
    logic             g_active;
    logic             tmo;

    assign g_cyc    = gnt_q ? wb_m1.cyc : wb_m0.cyc;
    assign g_active = g_cyc & (gnt_q ? wb_m1.stb : wb_m0.stb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration, release and strobe watchdog
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = '0;
        tmo     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb_m0.cyc || wb_m1.cyc) begin
                    state_d = BUSY;
                    gnt_d   = (wb_m0.cyc && wb_m1.cyc) ? ~last_q : ~wb_m0.cyc;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end else if (g_active && !wb_s.ack && !wb_s.err) begin
                    if (cnt_q == CNT_LAST) begin
                        tmo = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // Bus steering: only the granted master sees the slave, idle bus is all zeros
    always_comb begin
        o_gnt     = 2'b00;
        o_timeout = tmo;
        wb_s.cyc  = 1'b0;
        wb_s.stb  = 1'b0;
        wb_s.we   = 1'b0;
        wb_s.adr  = '0;
        wb_s.dat  = '0;
        wb_s.sel  = '0;
        wb_s.cti  = '0;
        wb_s.bte  = '0;
        wb_m0.rdt = '0;
        wb_m0.ack = 1'b0;
        wb_m0.err = 1'b0;
        wb_m1.rdt = '0;
        wb_m1.ack = 1'b0;
        wb_m1.err = 1'b0;
        if (state_q == BUSY) begin
            o_gnt    = gnt_q ? 2'b10 : 2'b01;
            wb_s.cyc = g_cyc;
            wb_s.stb = (gnt_q ? wb_m1.stb : wb_m0.stb) & ~tmo;
            wb_s.we  = gnt_q ? wb_m1.we  : wb_m0.we;
            wb_s.adr = gnt_q ? wb_m1.adr : wb_m0.adr;
            wb_s.dat = gnt_q ? wb_m1.dat : wb_m0.dat;
            wb_s.sel = gnt_q ? wb_m1.sel : wb_m0.sel;
            wb_s.cti = gnt_q ? wb_m1.cti : wb_m0.cti;
            wb_s.bte = gnt_q ? wb_m1.bte : wb_m0.bte;
            if (gnt_q) begin
                wb_m1.rdt = wb_s.rdt;
                wb_m1.ack = wb_s.ack;
                wb_m1.err = wb_s.err | tmo;
            end else begin
                wb_m0.rdt = wb_s.rdt;
                wb_m0.ack = wb_s.ack;
                wb_m0.err = wb_s.err | tmo;
            end
        end
    end
endmodule
